spram_ctrl: RTL and testbench
=============================

SPRAM_CTRL -- requirements
Module: spram_ctrl

Interface
REQ-001 SHALL have parameters: ADDR_W, default 14, SPRAM word-address width; DATA_W, default 16, SPRAM word width.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; every register samples its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have write channel ports: wr_valid input 1; wr_ready output 1; wr_addr input ADDR_W; wr_data input DATA_W.
REQ-005 SHALL have burst command ports: start input 1; busy output 1; base_addr input ADDR_W; len input ADDR_W (word count, 0 = no-op).
REQ-006 SHALL have read stream ports: rd_valid output 1; rd_ready input 1; rd_data output DATA_W; rd_last output 1; done output 1 (single-cycle pulse).
REQ-007 SHALL have SPRAM master ports: mem_we output 1; mem_addr output ADDR_W; mem_din output DATA_W; mem_dout input DATA_W (valid one cycle after a read address).

Function
REQ-008 SHALL have exactly one SPRAM access per cycle: one write, one read issue, or idle.
REQ-009 SHALL have the write handshake complete when wr_valid and wr_ready are both high; mem_we=1, mem_addr=wr_addr, mem_din=wr_data are registered and presented the next cycle.
REQ-010 SHALL keep wr_ready high in every state; writes take priority over read issue, and a write-cycle stalls the burst by one cycle.
REQ-011 SHALL use FSM states IDLE, BURST, DRAIN.
REQ-012 SHALL accept start only in IDLE (busy=0); in other states start is ignored.
REQ-013 SHALL, on start with len=0, stay IDLE and pulse done the next cycle.
REQ-014 SHALL, on start with len>0, latch base_addr and len and enter BURST; busy=1 from the next cycle until return to IDLE.
REQ-015 SHALL, in BURST, issue read address base_addr+i for i=0..len-1, modulo 2^ADDR_W (0x3FFF wraps to 0x0000).
REQ-016 SHALL issue a read only when no write is accepted that cycle and fifo_count+inflight < 2 (credit rule); no word is ever dropped.
REQ-017 SHALL capture mem_dout into a 2-entry FIFO exactly one cycle after each read issue.
REQ-018 SHALL drive rd_valid while the FIFO is non-empty; a word pops on rd_valid and rd_ready; rd_data and rd_valid hold stable while rd_ready=0.
REQ-019 SHALL assert rd_last with the word for i=len-1 only.
REQ-020 SHALL go BURST->DRAIN after issuing index len-1, and DRAIN->IDLE when the rd_last word pops, with done pulsed in that pop cycle.
REQ-021 SHALL sustain one word per cycle when rd_ready is held high and there are no writes.
REQ-022 SHALL NOT provide read-after-write hazard protection; write/read ordering is defined by issue order alone.

Reset
REQ-023 SHALL, on reset, immediately force: state IDLE; busy=0, rd_valid=0, rd_last=0, done=0, mem_we=0, mem_addr=0, mem_din=0, rd_data=0; FIFO empty; inflight=0.
REQ-024 SHALL, on reset mid-burst, abort the burst; no partial word is presented after release.

Structure
REQ-025 SHALL take ADDR_W/DATA_W defaults and the state enum from shared package spram_pkg.
REQ-026 SHALL place the 2-entry FIFO in sub-module spram_rd_fifo (push, pop, count, head data/last).

Verification
REQ-027 SHALL verify a write: wr_valid with addr 1, data 4567 -> next cycle mem_we=1, mem_addr=1, mem_din=4567; then a burst base 1, len 1 -> rd_data=4567, rd_last=1, done pulse.
REQ-028 SHALL verify streaming: memory 10..13 preloaded with 0xA0..0xA3, burst base 10, len 4, rd_ready=1 -> four consecutive rd_valid cycles with 0xA0..0xA3, rd_last on 0xA3.
REQ-029 SHALL verify backpressure: same burst with rd_ready=0 for 5 cycles -> at most 2 reads issued, rd_data stays 0xA0, and all four words arrive in order after release.
REQ-030 SHALL verify wrap: base 0x3FFE, len 3 -> addresses 0x3FFE, 0x3FFF, 0x0000.
REQ-031 SHALL verify contention and no-op: a write during a burst delays the next read issue by one cycle; len=0 gives done one cycle after start with busy=0.
REQ-032 SHALL verify reset mid-burst: reset asserted after 2 of 4 words -> all outputs 0 within the same cycle; a fresh burst afterwards runs correctly.

Source files
------------

// File: rtl/spram_pkg.sv
// Shared definitions for the SPRAM burst-read controller.
//   ADDR_W_DEF / DATA_W_DEF : default SPRAM word-address and word widths
//   state_t                 : controller FSM states
package spram_pkg;
    localparam int ADDR_W_DEF = 14;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        DRAIN
    } state_t;
endpackage

// File: rtl/spram_rd_fifo.sv
// Two-entry read-return FIFO with a per-word "last" flag.
//   push/push_data/push_last : enqueue one word (caller guarantees not full)
//   pop                      : dequeue head word (caller guarantees not empty)
//   count                    : occupancy 0..2
//   head_data/head_last      : current head word, held stable until popped
module spram_rd_fifo import spram_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              push_last,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [1:0]        count,
    output logic [DATA_W-1:0] head_data,
    output logic              head_last
);
    logic [1:0][DATA_W-1:0] data_q;
    logic [1:0]             last_q;
    logic                   wr_ptr;
    logic                   rd_ptr;

    // Storage is reset too so the head reads as zero while in reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
            last_q <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                data_q[wr_ptr] <= push_data;
                last_q[wr_ptr] <= push_last;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end

    assign head_data = data_q[rd_ptr];
    assign head_last = last_q[rd_ptr];
endmodule

// File: rtl/spram_ctrl.sv
// Single-port SPRAM controller: a write channel plus a burst-read engine that
// streams len words starting at base_addr through a 2-entry FIFO.
//   clk, reset                         : clock, async active-high reset
//   wr_valid/wr_ready/wr_addr/wr_data  : write channel (always ready)
//   start/busy/base_addr/len           : burst command (len=0 is a no-op)
//   rd_valid/rd_ready/rd_data/rd_last  : read stream; done pulses on last pop
//   mem_we/mem_addr/mem_din/mem_dout   : SPRAM port, dout one cycle after addr
module spram_ctrl import spram_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    output logic              busy,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] len,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              done,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);
    state_t            state;
    logic [ADDR_W-1:0] rd_addr_q;       // next burst address to read
    logic [ADDR_W-1:0] rd_addr_d;
    logic [ADDR_W-1:0] remain_q;        // words still to issue
    logic              inflight_q;      // read on the port last cycle, data on mem_dout now
    logic              inflight_last_q;
    logic              done_q;          // done pulse for a len=0 command
    logic [1:0]        fifo_count;
    logic              head_last;
    logic              wr_fire;
    logic              pop;
    logic              issue;
    logic [2:0]        occ;

    assign wr_ready = 1'b1;
    assign wr_fire  = wr_valid & wr_ready;
    assign busy     = (state != IDLE);
    assign rd_valid = (fifo_count != 2'd0);
    assign pop      = rd_valid & rd_ready;
    assign rd_last  = rd_valid & head_last;
    assign done     = done_q | (pop & head_last);

    // FIFO occupancy as seen at the next edge: current words minus this
    // cycle's pop plus the word landing from the read already on the port.
    // A new read is only issued if it is guaranteed a slot.
    always_comb occ = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);

    // mem_addr is pre-loaded with the next burst address whenever the port is
    // not carrying a write, so a read "issues" in any BURST cycle where
    // mem_we is low and credit is available. A registered write therefore
    // costs the burst exactly one cycle.
    assign issue = (state == BURST) && !mem_we && (occ < 3'd2);

    always_comb begin
        rd_addr_d = rd_addr_q;
        if (state == IDLE && start && len != '0) rd_addr_d = base_addr;
        else if (issue)                          rd_addr_d = rd_addr_q + ADDR_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            rd_addr_q       <= '0;
            remain_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
            mem_we          <= 1'b0;
            mem_addr        <= '0;
            mem_din         <= '0;
        end else begin
            done_q          <= 1'b0;
            inflight_q      <= issue;
            inflight_last_q <= issue && (remain_q == ADDR_W'(1));
            rd_addr_q       <= rd_addr_d;

            case (state)
                IDLE: if (start) begin
                    if (len == '0) done_q <= 1'b1;
                    else begin
                        state    <= BURST;
                        remain_q <= len;
                    end
                end
                BURST: if (issue) begin
                    remain_q <= remain_q - ADDR_W'(1);
                    if (remain_q == ADDR_W'(1)) state <= DRAIN;
                end
                DRAIN: if (pop && head_last) state <= IDLE;
                default: state <= IDLE;
            endcase

            if (wr_fire) begin
                mem_we   <= 1'b1;
                mem_addr <= wr_addr;
                mem_din  <= wr_data;
            end else begin
                mem_we   <= 1'b0;
                mem_addr <= rd_addr_d;
            end
        end
    end

    spram_rd_fifo #(.DATA_W(DATA_W)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight_q),
        .push_last (inflight_last_q),
        .push_data (mem_dout),
        .pop       (pop),
        .count     (fifo_count),
        .head_data (rd_data),
        .head_last (head_last)
    );
endmodule

// File: tb/tb_spram_ctrl.sv
module tb_spram_ctrl;
    localparam int AW = 14;
    localparam int DW = 16;

    logic          clk;
    logic          reset;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          start;
    logic          busy;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] len;
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic          rd_last;
    logic          done;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } word_t;

    word_t         exp_q[$];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    logic [DW-1:0] mem     [0:(1<<AW)-1];
    int            n_tests = 0;
    int            n_fail  = 0;
    int            cyc     = 0;
    int            n_pops  = 0;
    int            done_cyc = 0;
    int            start_cyc = 0;
    int            pop_cyc[$];

    spram_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .busy(busy), .base_addr(base_addr), .len(len),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .done(done),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous SPRAM: data for the address on the port appears next cycle.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_din;
        mem_dout <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every popped word must match the next expected word.
    always @(negedge clk) begin
        if (!reset) begin
            if (done) done_cyc = cyc;
            if (rd_valid && rd_ready) begin
                n_pops++;
                pop_cyc.push_back(cyc);
                if (exp_q.size() == 0) chk("extra_word", 32'(rd_data), 32'hdead);
                else begin
                    word_t w;
                    w = exp_q.pop_front();
                    chk("rd_data", 32'(rd_data), 32'(w.data));
                    chk("rd_last", 32'(rd_last), 32'(w.last));
                    chk("done_on_pop", 32'(done), 32'(w.last));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string where);
        chk({where, "_busy"},     32'(busy),     32'd0);
        chk({where, "_rd_valid"}, 32'(rd_valid), 32'd0);
        chk({where, "_rd_last"},  32'(rd_last),  32'd0);
        chk({where, "_done"},     32'(done),     32'd0);
        chk({where, "_mem_we"},   32'(mem_we),   32'd0);
        chk({where, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({where, "_mem_din"},  32'(mem_din),  32'd0);
        chk({where, "_rd_data"},  32'(rd_data),  32'd0);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        ref_mem[a] = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic start_burst(input logic [AW-1:0] b, input logic [AW-1:0] l);
        word_t w;
        for (int i = 0; i < int'(l); i++) begin
            w.data = ref_mem[b + AW'(i)];
            w.last = (i == int'(l) - 1);
            exp_q.push_back(w);
        end
        base_addr = b;
        len       = l;
        start     = 1'b1;
        start_cyc = cyc;
        tick();
        start = 1'b0;
        if (l != '0) chk("busy_after_start", 32'(busy), 32'd1);
    endtask

    // Run until the burst has fully drained; optional random backpressure
    // and random writes to an address outside the burst window.
    task automatic wait_idle(input bit rnd, input logic [AW-1:0] far);
        int k;
        for (k = 0; k < 300; k++) begin
            if (exp_q.size() == 0 && !busy) break;
            rd_ready = rnd ? 1'($urandom_range(1)) : 1'b1;
            if (rnd && $urandom_range(5) == 0) begin
                wr_valid = 1'b1;
                wr_addr  = far;
                wr_data  = DW'($urandom);
                ref_mem[far] = wr_data;
            end else wr_valid = 1'b0;
            tick();
        end
        wr_valid = 1'b0;
        chk("idle_timeout", 32'(k < 300), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0;
        int t1;
        int n0;
        logic [AW-1:0] b;
        logic [AW-1:0] l;
        word_t w;

        reset = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; base_addr = '0; len = '0; rd_ready = 1'b0;
        tick(); tick();
        check_zero("reset");
        chk("wr_ready_reset", 32'(wr_ready), 32'd1);
        reset = 1'b0;
        tick();

        // Single write is presented on the port the following cycle.
        do_write(AW'(1), 16'h4567);
        chk("wr_mem_we",   32'(mem_we),   32'd1);
        chk("wr_mem_addr", 32'(mem_addr), 32'd1);
        chk("wr_mem_din",  32'(mem_din),  32'h4567);
        tick();
        chk("wr_mem_we_clr", 32'(mem_we), 32'd0);
        rd_ready = 1'b1;
        start_burst(AW'(1), AW'(1));
        wait_idle(1'b0, '0);

        // Streaming at full rate.
        for (int i = 0; i < 4; i++) do_write(AW'(10 + i), DW'(16'hA0 + i));
        pop_cyc.delete();
        rd_ready = 1'b1;
        start_burst(AW'(10), AW'(4));
        wait_idle(1'b0, '0);
        chk("stream_pops", 32'(pop_cyc.size()), 32'd4);
        for (int i = 1; i < pop_cyc.size(); i++)
            chk("stream_gap", 32'(pop_cyc[i] - pop_cyc[0]), 32'(i));
        t0 = done_cyc - start_cyc;

        // Backpressure: 5 stalled cycles. Word 13 is rewritten late in the
        // stall; with only two reads allowed out, it must be read afterwards.
        rd_ready = 1'b0;
        start_burst(AW'(10), AW'(4));
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                wr_valid = 1'b1; wr_addr = AW'(13); wr_data = 16'hB3;
                ref_mem[13] = 16'hB3;
                w = exp_q[3]; w.data = 16'hB3; exp_q[3] = w;
            end
            @(negedge clk);
            if (i >= 2) begin
                chk("bp_rd_valid", 32'(rd_valid), 32'd1);
                chk("bp_rd_data",  32'(rd_data),  32'hA0);
            end
            tick();
            wr_valid = 1'b0;
        end
        wait_idle(1'b0, '0);

        // Address wrap.
        do_write(AW'(14'h3FFE), 16'h1111);
        do_write(AW'(14'h3FFF), 16'h2222);
        do_write(AW'(14'h0000), 16'h3333);
        start_burst(AW'(14'h3FFE), AW'(3));
        wait_idle(1'b0, '0);

        // Contention: one write during the burst costs exactly one cycle.
        rd_ready = 1'b1;
        start_burst(AW'(10), AW'(4));
        wr_valid = 1'b1; wr_addr = AW'(100); wr_data = 16'h5A5A;
        ref_mem[100] = 16'h5A5A;
        tick();
        wr_valid = 1'b0;
        wait_idle(1'b0, '0);
        t1 = done_cyc - start_cyc;
        chk("contention_delay", 32'(t1 - t0), 32'd1);

        // len = 0 is a no-op with a done pulse.
        start_burst(AW'(5), AW'(0));
        chk("noop_done", 32'(done), 32'd1);
        chk("noop_busy", 32'(busy), 32'd0);
        tick();
        chk("noop_done_clr", 32'(done), 32'd0);

        // Reset after two of four words.
        for (int i = 0; i < 4; i++) do_write(AW'(20 + i), DW'(16'hC0 + i));
        n0 = n_pops;
        start_burst(AW'(20), AW'(4));
        for (int k = 0; k < 50; k++) begin
            if (n_pops >= n0 + 2) break;
            tick();
        end
        chk("mid_pops", 32'(n_pops - n0), 32'd2);
        reset = 1'b1;
        #1;
        check_zero("midrst");
        exp_q.delete();
        tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_rd_valid", 32'(rd_valid), 32'd0);
        end
        start_burst(AW'(20), AW'(4));
        wait_idle(1'b0, '0);

        // Random bursts with random backpressure and interleaved writes.
        for (int r = 0; r < 10; r++) begin
            b = AW'($urandom_range((1 << AW) - 1));
            l = AW'($urandom_range(6, 1));
            for (int i = 0; i < int'(l); i++) do_write(b + AW'(i), DW'($urandom));
            start_burst(b, l);
            wait_idle(1'b1, b ^ AW'(14'h2000));
            chk("rnd_drained", 32'(exp_q.size()), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
